// File: rtl/ysyx_22050019_mem_arbiter.sv
// ysyx_22050019_mem_arbiter: shares one data-memory port between the IFU and
// the LSU. It accepts one request in IDLE, registers it onto mem_*, and drives
// mem_req in SEND. It then waits for mem_rvalid and routes the response back
// to the owner.
// Optional build macro: ARB_RR_EN selects round-robin on ties. When it is
// undefined, the LSU has fixed priority over the IFU.
module ysyx_22050019_mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_gnt,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req,
    input  logic                lsu_we,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_gnt,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;
    typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

    state_t state, state_nxt;
    owner_t owner;
    logic   pick_lsu;
    logic   accept;
    logic   done;

    // Arbitration: decide which requester wins if a request is accepted now
    always_comb begin
`ifdef ARB_RR_EN
        // On a tie, the requester that did not own the last transaction wins
        pick_lsu = lsu_req && (!ifu_req || owner == OWN_IFU);
`else
        pick_lsu = lsu_req;
`endif
        accept = (state == S_IDLE) && (ifu_req || lsu_req);
    end

    // Next state, grants and response routing
    always_comb begin
        state_nxt  = state;
        ifu_gnt    = 1'b0;
        lsu_gnt    = 1'b0;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    lsu_gnt   = pick_lsu;
                    ifu_gnt   = !pick_lsu;
                    state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (mem_gnt) begin
                    done      = mem_rvalid;
                    state_nxt = mem_rvalid ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        mem_req    = (state == S_SEND);
        ifu_rvalid = done && (owner == OWN_IFU);
        lsu_rvalid = done && (owner == OWN_LSU);
        ifu_rdata  = ifu_rvalid ? mem_rdata : '0;
        lsu_rdata  = lsu_rvalid ? mem_rdata : '0;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Latch the winning request onto the memory port; it is held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner     <= OWN_IFU;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else if (accept) begin
            owner     <= pick_lsu ? OWN_LSU : OWN_IFU;
            mem_we    <= pick_lsu && lsu_we;
            mem_addr  <= pick_lsu ? lsu_addr : ifu_addr;
            mem_wdata <= pick_lsu ? lsu_wdata : '0;
            mem_wmask <= pick_lsu ? lsu_wmask : '0;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_mem_arbiter.sv
// Testbench for ysyx_22050019_mem_arbiter. The expected tie order follows
// ARB_RR_EN when that macro is defined.
module tb_ysyx_22050019_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req, ifu_gnt, ifu_rvalid;
    logic [63:0] ifu_addr, ifu_rdata;
    logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    typedef struct packed {
        logic        is_lsu;
        logic [63:0] data;
    } rsp_t;

    rsp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    ysyx_22050019_mem_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge; any response is checked against the scoreboard
    task automatic at_neg();
        rsp_t r;
        @(negedge clk);
        if (ifu_rvalid || lsu_rvalid) begin
            if (sb.size() == 0) begin
                chk("spurious_rvalid", {62'd0, ifu_rvalid, lsu_rvalid}, 64'd0);
            end else begin
                r = sb.pop_front();
                chk("rsp_lsu_rvalid", lsu_rvalid, r.is_lsu);
                chk("rsp_ifu_rvalid", ifu_rvalid, !r.is_lsu);
                chk("rsp_rdata", r.is_lsu ? lsu_rdata : ifu_rdata, r.data);
                chk("rsp_other_rdata", r.is_lsu ? ifu_rdata : lsu_rdata, 64'd0);
            end
        end else begin
            chk("quiet_rdata", ifu_rdata | lsu_rdata, 64'd0);
        end
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_send(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                            input logic [7:0] wm);
        chk("send_mem_req", mem_req, 1'b1);
        chk("send_mem_we", mem_we, we);
        chk("send_mem_addr", mem_addr, addr);
        if (we) chk("send_mem_wdata", mem_wdata, wd);
        chk("send_mem_wmask", {56'd0, mem_wmask}, {56'd0, wm});
        chk("send_no_gnt", {62'd0, ifu_gnt, lsu_gnt}, 64'd0);
    endtask

    // Serve one transaction from the SEND cycle. The first gdly cycles have no
    // grant and a stray mem_rvalid. The response comes rdly cycles after mem_gnt.
    task automatic run_mem(input int unsigned gdly, input int unsigned rdly, input logic [63:0] rd,
                           input logic we, input logic [63:0] addr, input logic [63:0] wd,
                           input logic [7:0] wm);
        for (int unsigned i = 0; i < gdly; i++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_0BAD;
            at_neg(); chk_send(we, addr, wd, wm); to_next();
        end
        mem_gnt = 1'b1; mem_rvalid = (rdly == 0); mem_rdata = rd;
        at_neg(); chk_send(we, addr, wd, wm); to_next();
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        if (rdly > 0) begin
            for (int unsigned i = 1; i < rdly; i++) begin
                at_neg();
                chk("wait_mem_req", mem_req, 1'b0);
                chk("wait_no_gnt", {62'd0, ifu_gnt, lsu_gnt}, 64'd0);
                to_next();
            end
            mem_rvalid = 1'b1; mem_rdata = rd;
            at_neg(); chk("wait_mem_req", mem_req, 1'b0); to_next();
            mem_rvalid = 1'b0; mem_rdata = '0;
        end
        chk("sb_drained", sb.size(), 64'd0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        ifu_req = 0; ifu_addr = '0;
        lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        at_neg();
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
        chk("rst_gnt_rvalid", {60'd0, ifu_gnt, lsu_gnt, ifu_rvalid, lsu_rvalid}, 64'd0);
        to_next();
        rst_n = 1'b1;
    endtask

    initial begin
        logic exp_lsu;
        logic last_lsu;
        logic [63:0] d;

        apply_reset();

        // Single IFU read: gnt c0, mem_gnt c1, mem_rvalid c3
        ifu_req = 1; ifu_addr = 64'h8000_0000;
        at_neg();
        chk("t1_ifu_gnt", ifu_gnt, 1'b1);
        chk("t1_lsu_gnt", lsu_gnt, 1'b0);
        chk("t1_mem_req_c0", mem_req, 1'b0);
        sb.push_back('{1'b0, 64'h0000_0413});
        to_next();
        ifu_req = 0; ifu_addr = '0;
        run_mem(0, 2, 64'h0000_0413, 1'b0, 64'h8000_0000, 64'd0, 8'h00);

        // LSU store: attributes change after gnt, mem_* must hold
        lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF; lsu_wmask = 8'h0F;
        at_neg();
        chk("t2_lsu_gnt", lsu_gnt, 1'b1);
        chk("t2_ifu_gnt", ifu_gnt, 1'b0);
        sb.push_back('{1'b1, 64'h0000_1234});
        to_next();
        lsu_req = 0; lsu_we = 0; lsu_addr = 64'hFFFF; lsu_wdata = '0; lsu_wmask = 8'hFF;
        run_mem(2, 1, 64'h0000_1234, 1'b1, 64'h8000_1000, 64'hDEAD_BEEF, 8'h0F);

        // Tie from reset: LSU first, IFU in the IDLE cycle after the LSU response
        apply_reset();
        ifu_req = 1; ifu_addr = 64'h8000_0100;
        lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_2000; lsu_wmask = 8'hFF;
        at_neg();
        chk("t3_lsu_first", lsu_gnt, 1'b1);
        chk("t3_ifu_wait", ifu_gnt, 1'b0);
        sb.push_back('{1'b1, 64'hAAAA_0001});
        to_next();
        lsu_req = 0;
        run_mem(0, 1, 64'hAAAA_0001, 1'b0, 64'h8000_2000, 64'd0, 8'hFF);
        at_neg();
        chk("t3_ifu_gnt", ifu_gnt, 1'b1);
        sb.push_back('{1'b0, 64'hBBBB_0002});
        to_next();
        ifu_req = 0;
        run_mem(1, 0, 64'hBBBB_0002, 1'b0, 64'h8000_0100, 64'd0, 8'h00);

        // Back-to-back ties, four transactions with both requests held
        apply_reset();
        ifu_req = 1; ifu_addr = 64'h8000_0200;
        lsu_req = 1; lsu_we = 0; lsu_addr = 64'h8000_3000; lsu_wmask = 8'h03;
        last_lsu = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
            exp_lsu = !last_lsu;
`else
            exp_lsu = 1'b1;
`endif
            d = 64'hC0DE_0000 + 64'(k);
            at_neg();
            chk("t4_lsu_gnt", lsu_gnt, exp_lsu);
            chk("t4_ifu_gnt", ifu_gnt, !exp_lsu);
            sb.push_back('{exp_lsu, d});
            to_next();
            run_mem(0, 0, d, 1'b0, exp_lsu ? 64'h8000_3000 : 64'h8000_0200, 64'd0,
                    exp_lsu ? 8'h03 : 8'h00);
            last_lsu = exp_lsu;
        end
        ifu_req = 0; lsu_req = 0;

        // mem_gnt delayed 5 cycles, response in the grant cycle, then IDLE at once
        ifu_req = 1; ifu_addr = 64'h8000_0400;
        at_neg();
        chk("t5_ifu_gnt", ifu_gnt, 1'b1);
        sb.push_back('{1'b0, 64'h1357_9BDF});
        to_next();
        ifu_req = 0;
        run_mem(5, 0, 64'h1357_9BDF, 1'b0, 64'h8000_0400, 64'd0, 8'h00);
        lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_5000; lsu_wdata = 64'h55; lsu_wmask = 8'h01;
        at_neg();
        chk("t5_idle_mem_req", mem_req, 1'b0);
        chk("t5_idle_gnt", lsu_gnt, 1'b1);
        sb.push_back('{1'b1, 64'h0});
        to_next();
        lsu_req = 0;
        run_mem(0, 3, 64'h0, 1'b1, 64'h8000_5000, 64'h55, 8'h01);

        // Reset while waiting for the store response, then a late response
        lsu_req = 1; lsu_we = 1; lsu_addr = 64'h8000_6000; lsu_wdata = 64'hFACE; lsu_wmask = 8'hFF;
        at_neg();
        chk("t6_lsu_gnt", lsu_gnt, 1'b1);
        to_next();
        lsu_req = 0; mem_gnt = 1;
        at_neg();
        chk("t6_send_addr", mem_addr, 64'h8000_6000);
        to_next();
        mem_gnt = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_mem_req", mem_req, 1'b0);
        chk("t6_rst_mem_we", mem_we, 1'b0);
        chk("t6_rst_mem_addr", mem_addr, 64'd0);
        chk("t6_rst_mem_wdata", mem_wdata, 64'd0);
        chk("t6_rst_mem_wmask", {56'd0, mem_wmask}, 64'd0);
        at_neg();
        to_next();
        rst_n = 1'b1;
        mem_rvalid = 1; mem_rdata = 64'hDEAD;
        at_neg();
        chk("t6_late_lsu_rvalid", lsu_rvalid, 1'b0);
        chk("t6_late_ifu_rvalid", ifu_rvalid, 1'b0);
        chk("t6_late_mem_req", mem_req, 1'b0);
        to_next();
        mem_rvalid = 0; mem_rdata = '0;
        at_neg();
        to_next();
        chk("final_sb_empty", sb.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
